// File: rtl/had_pkg.sv
// Shared types and helpers for the Hadamard coefficient display path.
package had_pkg;

  localparam int unsigned HAD_COEFF_W = 7;
  localparam int unsigned HAD_BLK_LEN = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } disp_state_t;

  // {sign, |x|}; |x| keeps the full coefficient width so the most negative value has no overflow.
  function automatic logic [HAD_COEFF_W:0] sign_mag(input logic [HAD_COEFF_W-1:0] x);
    logic [HAD_COEFF_W-1:0] mag;
    mag = x[HAD_COEFF_W-1] ? -x : x;
    return {x[HAD_COEFF_W-1], mag};
  endfunction

endpackage

// File: rtl/had_hold_timer.sv
// Loadable down-counter; stops at zero and flags it.
module had_hold_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/had_coeff_display.sv
// Pops Hadamard coefficients one at a time, shows them in sign-magnitude on the LEDs for a
// fixed hold time, and logs each block into a readback buffer.
module had_coeff_display
  import had_pkg::*;
#(
  parameter int unsigned DW          = HAD_COEFF_W,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned BLK_LEN     = HAD_BLK_LEN,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  input  logic          enable,
  output logic [DW:0]   led_out,
  output logic [3:0]    coeff_idx,
  output logic          disp_valid,
  output logic          block_done,
  input  logic [3:0]    rb_addr,
  output logic [DW-1:0] rb_data
);

  localparam int unsigned CntW    = $clog2(HOLD_CYCLES);
  localparam logic [3:0]  LastIdx = 4'(BLK_LEN - 1);

  disp_state_t state_q, state_d;
  logic [DW:0]   led_q;
  logic [3:0]    idx_q;
  logic [3:0]    wr_idx_q, wr_idx_d;
  logic          valid_q;
  logic          done_q;
  logic [DW-1:0] rb_q;
  logic [DW-1:0] blk_buf_q [BLK_LEN];

  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_zero;
  logic            pop, capture, expire;

  // Gated by rst_n so no pop can leak out while reset is held with a non-empty FIFO.
  assign pop     = rst_n && (state_q == StIdle) && enable && !fifo_empty;
  assign capture = (state_q == StFetch) && tmr_zero;
  assign expire  = (state_q == StHold) && tmr_zero;

  // One timer serves both the read-latency wait and the display hold.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d  = StFetch;
          tmr_load = 1'b1;
          tmr_val  = CntW'(RD_LAT - 1);
        end
      end
      StFetch: begin
        if (tmr_zero) begin
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = CntW'(HOLD_CYCLES - 1);
        end
      end
      StHold: begin
        if (tmr_zero) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_idx_d = (wr_idx_q == LastIdx) ? 4'd0 : wr_idx_q + 4'd1;

  had_hold_timer #(
    .Width (CntW)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      led_q    <= '0;
      idx_q    <= '0;
      wr_idx_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      rb_q     <= '0;
    end else begin
      state_q <= state_d;
      rb_q    <= blk_buf_q[rb_addr];
      done_q  <= expire && (idx_q == LastIdx);
      if (capture) begin
        led_q    <= sign_mag(fifo_dout);
        idx_q    <= wr_idx_q;
        wr_idx_q <= wr_idx_d;
        valid_q  <= 1'b1;
      end else if ((state_q == StIdle) && !enable) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Buffer contents survive reset; readback always sees pre-write data on a same-address hit.
  always_ff @(posedge clk) begin
    if (capture) blk_buf_q[wr_idx_q] <= fifo_dout;
  end

  assign fifo_rd_en = pop;
  assign led_out    = led_q;
  assign coeff_idx  = idx_q;
  assign disp_valid = valid_q;
  assign block_done = done_q;
  assign rb_data    = rb_q;

endmodule
